// File: rtl/dcache_pkg.sv
// Shared geometry defaults, FSM state encoding and address-field helpers for the data cache.
// Field helpers return 32-bit values; callers truncate to their own field widths.
package dcache_pkg;

  localparam int DC_INDEX_W  = 4;
  localparam int DC_OFFSET_W = 2;
  localparam int DC_ADDR_W   = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w,
                                           input int offset_w);
    return addr >> (index_w + offset_w + 2);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w,
                                             input int offset_w);
    return (addr >> (offset_w + 2)) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int offset_w);
    return (addr >> 2) & ((32'd1 << offset_w) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache.
// master = pipeline/memory environment, slave = the cache controller.
interface dcache_if import dcache_pkg::*; #(
  parameter int ADDR_W = DC_ADDR_W
);
  logic              cpu_read;
  logic [3:0]        cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              data_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, data_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, data_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dcache_array.sv
// Valid bits, tag RAM and data RAM of the direct-mapped cache; the only storage in the block.
// Asynchronous read, synchronous byte-enabled write; valid-clear beats tag-set on the same line.
module dcache_array import dcache_pkg::*; #(
  parameter int INDEX_W  = DC_INDEX_W,
  parameter int OFFSET_W = DC_OFFSET_W,
  parameter int TAG_W    = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W - 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [OFFSET_W-1:0] rd_offset_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [31:0]         rd_data_o,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic                wr_en_i,
  input  logic [OFFSET_W-1:0] wr_offset_i,
  input  logic [3:0]          wr_be_i,
  input  logic [31:0]         wr_data_i,
  input  logic                tag_set_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic                valid_clr_i
);
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES*WORDS];

  logic [INDEX_W+OFFSET_W-1:0] rd_ptr;
  logic [INDEX_W+OFFSET_W-1:0] wr_ptr;

  assign rd_ptr     = {rd_index_i, rd_offset_i};
  assign wr_ptr     = {wr_index_i, wr_offset_i};
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (valid_clr_i) begin
      valid_q[wr_index_i] <= 1'b0;
    end else if (tag_set_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_set_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) begin
          data_q[wr_ptr][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate D-cache controller; hits answer in the request
// cycle, misses refill over single-beat req/ack. DCACHE_STATS_EN adds hit/miss counter outputs.
module dcache_ctrl import dcache_pkg::*; #(
  parameter int INDEX_W  = DC_INDEX_W,
  parameter int OFFSET_W = DC_OFFSET_W,
  parameter int ADDR_W   = DC_ADDR_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;

  logic [1:0]          state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_nxt;
  logic [31:0]         rdata_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [3:0]          mem_wstrb_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                is_wr, hit, last_beat;
  logic                arr_valid;
  logic [TAG_W-1:0]    arr_tag;
  logic [31:0]         arr_data;

  logic                data_ready, lookup_hit, miss_start;
  logic                arr_wr_en, arr_tag_set, arr_valid_clr;
  logic [OFFSET_W-1:0] arr_wr_off;
  logic [3:0]          arr_be;
  logic [31:0]         arr_wdata;

  assign req_tag   = TAG_W'(addr_tag(32'(bus.cpu_addr), INDEX_W, OFFSET_W));
  assign req_idx   = INDEX_W'(addr_index(32'(bus.cpu_addr), INDEX_W, OFFSET_W));
  assign req_off   = OFFSET_W'(addr_offset(32'(bus.cpu_addr), OFFSET_W));
  assign is_wr     = |bus.cpu_write;
  assign hit       = arr_valid && (arr_tag == req_tag);
  assign last_beat = (beat_q == {OFFSET_W{1'b1}});
  assign beat_nxt  = beat_q + OFFSET_W'(1);

  dcache_array #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_index_i  (req_idx),
    .rd_offset_i (req_off),
    .rd_valid_o  (arr_valid),
    .rd_tag_o    (arr_tag),
    .rd_data_o   (arr_data),
    .wr_index_i  (req_idx),
    .wr_en_i     (arr_wr_en),
    .wr_offset_i (arr_wr_off),
    .wr_be_i     (arr_be),
    .wr_data_i   (arr_wdata),
    .tag_set_i   (arr_tag_set),
    .wr_tag_i    (req_tag),
    .valid_clr_i (arr_valid_clr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_wr) begin
          state_d = WRITE;
        end else if (bus.cpu_read && !hit) begin
          state_d = REFILL;
        end
      end
      REFILL:  if (bus.mem_ack && last_beat) state_d = DONE;
      WRITE:   if (bus.mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_ready    = 1'b0;
    lookup_hit    = 1'b0;
    miss_start    = 1'b0;
    arr_wr_en     = 1'b0;
    arr_wr_off    = req_off;
    arr_be        = 4'h0;
    arr_wdata     = bus.cpu_wdata;
    arr_tag_set   = 1'b0;
    arr_valid_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (!is_wr && bus.cpu_read) begin
          if (hit) begin
            data_ready = 1'b1;
            lookup_hit = 1'b1;
          end else begin
            miss_start    = 1'b1;
            arr_valid_clr = 1'b1;
          end
        end
      end
      REFILL: begin
        if (bus.mem_ack) begin
          arr_wr_en   = 1'b1;
          arr_wr_off  = beat_q;
          arr_be      = 4'hF;
          arr_wdata   = bus.mem_rdata;
          arr_tag_set = last_beat;
        end
      end
      WRITE: begin
        // Strobe-masked write only merges into a resident line; misses are not allocated.
        if (bus.mem_ack && hit) begin
          arr_wr_en = 1'b1;
          arr_be    = bus.cpu_write;
        end
      end
      DONE:    data_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q      <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_wr) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= bus.cpu_wdata;
            mem_wstrb_q <= bus.cpu_write;
          end else if (miss_start) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            beat_q     <= '0;
            mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            beat_q <= beat_nxt;
            if (beat_q == req_off) begin
              rdata_q <= bus.mem_rdata;
            end
            if (last_beat) begin
              mem_req_q <= 1'b0;
            end else begin
              mem_addr_q <= {req_tag, req_idx, beat_nxt, 2'b00};
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_ready = data_ready;
  assign bus.cpu_rdata  = lookup_hit ? arr_data : rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wstrb  = mem_wstrb_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a line-residency model plus a word-addressed memory model predict
// hit/miss, beat traffic and load data for directed and random accesses.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_if #(.ADDR_W(32)) dif ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (dif)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } beat_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_ack_cyc = 0;
  int          fixed_wait = 2;
  int          hits_m = 0;
  int          misses_m = 0;
  beat_t       beats[$];
  logic [31:0] mem_m [int unsigned];
  bit          mv [16];
  logic [23:0] mt [16];
  logic [31:0] last_rd;
  bit          last_hit;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int unsigned w);
    if (mem_m.exists(w)) return mem_m[w];
    return (w * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic int pick_wait();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
  endfunction

  // Memory responder: acks after a chosen number of idle cycles and logs every accepted beat.
  initial begin
    int    wcnt;
    beat_t bt;
    logic [31:0] w;
    dif.mem_ack   = 1'b0;
    dif.mem_rdata = 32'hDEADBEEF;
    wcnt = pick_wait();
    forever begin
      @(negedge clk);
      dif.mem_ack   = 1'b0;
      dif.mem_rdata = 32'hDEADBEEF;
      if (!rst_n) begin
        wcnt = pick_wait();
      end else if (dif.mem_req) begin
        if (wcnt == 0) begin
          bt.we    = dif.mem_we;
          bt.addr  = dif.mem_addr;
          bt.wdata = dif.mem_wdata;
          bt.strb  = dif.mem_wstrb;
          beats.push_back(bt);
          w = mem_rd(dif.mem_addr >> 2);
          if (dif.mem_we) begin
            for (int b = 0; b < 4; b++)
              if (dif.mem_wstrb[b]) w[8*b +: 8] = dif.mem_wdata[8*b +: 8];
            mem_m[dif.mem_addr >> 2] = w;
          end else begin
            dif.mem_rdata = w;
          end
          dif.mem_ack  = 1'b1;
          last_ack_cyc = cyc;
          wcnt = pick_wait();
        end else begin
          wcnt--;
        end
      end
    end
  end

  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st);
    logic [31:0] waddr, base;
    int          idx, n;
    logic [23:0] tag;
    bit          hit;
    waddr = addr & ~32'h3;
    base  = addr & ~32'hF;
    idx   = int'((addr >> 4) % 16);
    tag   = 24'(addr >> 8);
    hit   = !wr && mv[idx] && (mt[idx] == tag);
    beats.delete();
    @(negedge clk);
    dif.cpu_addr  = addr;
    dif.cpu_wdata = wd;
    dif.cpu_write = wr ? st : 4'h0;
    dif.cpu_read  = !wr;
    n = 0;
    #1;
    while (!dif.data_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("ready_seen", 32'(dif.data_ready), 32'd1);
    check_eq("req_low_at_ready", 32'(dif.mem_req), 32'd0);
    if (hit) begin
      check_eq("hit_latency", n, 0);
      check_eq("hit_no_beats", beats.size(), 0);
    end else begin
      check_eq("done_after_ack", cyc, last_ack_cyc + 1);
      if (wr) begin
        check_eq("st_beats", beats.size(), 1);
        if (beats.size() == 1) begin
          check_eq("st_we", 32'(beats[0].we), 32'd1);
          check_eq("st_addr", beats[0].addr, waddr);
          check_eq("st_wdata", beats[0].wdata, wd);
          check_eq("st_strb", 32'(beats[0].strb), 32'(st));
        end
      end else begin
        check_eq("rf_beats", beats.size(), 4);
        for (int k = 0; k < beats.size() && k < 4; k++) begin
          check_eq("rf_we", 32'(beats[k].we), 32'd0);
          check_eq("rf_addr", beats[k].addr, base + 32'(4 * k));
        end
        mv[idx] = 1'b1;
        mt[idx] = tag;
      end
    end
    if (!wr) begin
      check_eq("rd_data", dif.cpu_rdata, mem_rd(waddr >> 2));
      if (hit) hits_m++; else misses_m++;
    end
    last_rd  = dif.cpu_rdata;
    last_hit = hit;
    @(negedge clk);
    dif.cpu_read  = 1'b0;
    dif.cpu_write = 4'h0;
    #1;
    check_eq("ready_drop", 32'(dif.data_ready), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst_n         = 1'b0;
    dif.cpu_read  = 1'b0;
    dif.cpu_write = 4'h0;
    dif.cpu_addr  = '0;
    dif.cpu_wdata = '0;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    mem_m[32'h40 >> 2] = 32'h11;
    mem_m[32'h44 >> 2] = 32'h22;
    mem_m[32'h48 >> 2] = 32'h33;
    mem_m[32'h4C >> 2] = 32'h44;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(dif.data_ready), 32'd0);
    check_eq("rst_req", 32'(dif.mem_req), 32'd0);
    check_eq("rst_we", 32'(dif.mem_we), 32'd0);
    check_eq("rst_addr", dif.mem_addr, 32'd0);
    check_eq("rst_wdata", dif.mem_wdata, 32'd0);
    check_eq("rst_wstrb", 32'(dif.mem_wstrb), 32'd0);
    check_eq("rst_rdata", dif.cpu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_access(1'b0, 32'h40, 32'h0, 4'h0);
    check_eq("t1_cold_data", last_rd, 32'h11);
    fixed_wait = -1;
    do_access(1'b0, 32'h48, 32'h0, 4'h0);
    check_eq("t2_hit", 32'(last_hit), 32'd1);
    check_eq("t2_data", last_rd, 32'h33);
    do_access(1'b1, 32'h48, 32'hAABBCCDD, 4'b0011);
    do_access(1'b0, 32'h48, 32'h0, 4'h0);
    check_eq("t3_merge", last_rd, 32'h0000CCDD);
    do_access(1'b1, 32'h1000, 32'h12345678, 4'hF);
    do_access(1'b0, 32'h1000, 32'h0, 4'h0);
    check_eq("t4_no_alloc", 32'(last_hit), 32'd0);
    check_eq("t4_data", last_rd, 32'h12345678);
    do_access(1'b0, 32'h440, 32'h0, 4'h0);
    do_access(1'b0, 32'h40, 32'h0, 4'h0);
    check_eq("t5_evicted", 32'(last_hit), 32'd0);

    for (int i = 0; i < 250; i++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 9) < 3)
        do_access(1'b1, a | 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)));
      else
        do_access(1'b0, a, 32'h0, 4'h0);
    end

    // Abort a refill part-way through with an asynchronous reset.
    fixed_wait = 1;
    beats.delete();
    @(negedge clk);
    dif.cpu_addr = 32'h2040;
    dif.cpu_read = 1'b1;
    n = 0;
    while (beats.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_reached_beat2", 32'(beats.size() >= 2), 32'd1);
    #2;
    rst_n        = 1'b0;
    dif.cpu_read = 1'b0;
    #1;
    check_eq("abort_req", 32'(dif.mem_req), 32'd0);
    check_eq("abort_ready", 32'(dif.data_ready), 32'd0);
    check_eq("abort_rdata", dif.cpu_rdata, 32'd0);
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    hits_m   = 0;
    misses_m = 0;
`ifdef DCACHE_STATS_EN
    check_eq("abort_hit_cnt", hit_cnt, 32'd0);
    check_eq("abort_miss_cnt", miss_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b0, 32'h2040, 32'h0, 4'h0);
    check_eq("post_abort_miss", 32'(last_hit), 32'd0);
    fixed_wait = -1;
    do_access(1'b0, 32'h2044, 32'h0, 4'h0);
    check_eq("post_abort_hit", 32'(last_hit), 32'd1);
`ifdef DCACHE_STATS_EN
    check_eq("hit_cnt", hit_cnt, 32'(hits_m));
    check_eq("miss_cnt", miss_cnt, 32'(misses_m));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
